// File: rtl/cpu_bus_pkg.sv
// Shared types and address-map constants for the CPU bus responder.
// Optional feature macro: CPU_BUS_OPEN_BUS_EN (unmapped reads return the last bus byte).
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESPOND
  } state_t;

  localparam logic [15:0] WRAM_BASE          = 16'h0000;
  localparam logic [15:0] WRAM_LIMIT         = 16'h1FFF;
  localparam logic [7:0]  UNMAPPED_READ_DATA = 8'h00;

  // Offset compare keeps the check valid if the window is ever moved off zero.
  function automatic logic is_wram(input logic [15:0] addr);
    return (addr - WRAM_BASE) <= (WRAM_LIMIT - WRAM_BASE);
  endfunction

endpackage

// File: rtl/cpu_bus_responder_wram.sv
// Single-port work RAM with synchronous read-first output; contents are never reset.
module wram_sp #(
  parameter int unsigned ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [7:0]           wdata_i,
  output logic [7:0]           rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU bus slave: accepts one access at a time, inserts WAIT_STATES cycles, then pulses a response.
// Optional feature macro: CPU_BUS_OPEN_BUS_EN (unmapped reads return the open-bus register).
module cpu_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES    = 1,
  parameter int unsigned WRAM_ADDR_BITS = 11
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [15:0] address_i,
  input  logic [7:0]  data_i,
  input  logic        write_i,
  input  logic        request_i,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  output logic        busy_o
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       write_q, write_d;
  logic       mapped_q, mapped_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] data_q, data_d;
`ifdef CPU_BUS_OPEN_BUS_EN
  logic [7:0] open_bus_q, open_bus_d;
`endif

  logic       accept;
  logic       addr_mapped;
  logic       ram_en;
  logic [7:0] ram_rdata;
  logic [7:0] resp_byte;

  assign accept      = (state_q == ST_IDLE) && request_i && !reset_i;
  assign addr_mapped = is_wram(address_i);
  assign ram_en      = accept && addr_mapped;

  // Write commits and read is issued on the acceptance edge itself.
  wram_sp #(
    .ADDR_BITS(WRAM_ADDR_BITS)
  ) u_wram (
    .clk    (clock_i),
    .en_i   (ram_en),
    .we_i   (write_i),
    .addr_i (address_i[WRAM_ADDR_BITS-1:0]),
    .wdata_i(data_i),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    if (write_q) begin
      resp_byte = wdata_q;
    end else if (mapped_q) begin
      resp_byte = ram_rdata;
    end else begin
`ifdef CPU_BUS_OPEN_BUS_EN
      resp_byte = open_bus_q;
`else
      resp_byte = UNMAPPED_READ_DATA;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    mapped_d     = mapped_q;
    wdata_d      = wdata_q;
    data_d       = data_q;
`ifdef CPU_BUS_OPEN_BUS_EN
    open_bus_d   = open_bus_q;
`endif
    data_valid_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d  = write_i;
          mapped_d = addr_mapped;
          wdata_d  = data_i;
          if (WAIT_STATES != 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_RESPOND;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RESPOND;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESPOND: begin
        data_valid_o = 1'b1;
        data_d       = resp_byte;
`ifdef CPU_BUS_OPEN_BUS_EN
        open_bus_d   = resp_byte;
`endif
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      write_q    <= 1'b0;
      mapped_q   <= 1'b0;
      wdata_q    <= 8'h00;
      data_q     <= 8'h00;
`ifdef CPU_BUS_OPEN_BUS_EN
      open_bus_q <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      mapped_q   <= mapped_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
`ifdef CPU_BUS_OPEN_BUS_EN
      open_bus_q <= open_bus_d;
`endif
    end
  end

  // RAM data only exists during RESPOND, so the live byte is muxed straight out then.
  assign data_o = (state_q == ST_RESPOND) ? resp_byte : data_q;
  assign busy_o = (state_q != ST_IDLE);

endmodule
